// File: rtl/parking_gate_sequencer.sv
// rtl/parking_gate_sequencer.sv - per-lane timed gate sequences with a round-robin save arbiter
// Optional feature macro: PGS_RETRIGGER_EN (a press on a busy lane restarts its sequence).
module parking_gate_sequencer #(
    parameter int CHANNELS        = 2,
    parameter int CNT_W           = 12,
    parameter int IDX_W           = 1,
    parameter int ENTRY_TICKS     = 2000,
    parameter int EXIT_SHOW_TICKS = 2000,
    parameter int EXIT_PAY_TICKS  = 2000
) (
    input  logic                  ms,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   press,
    input  logic [CHANNELS-1:0]   is_out,
    output logic [3*CHANNELS-1:0] state,
    output logic [CHANNELS-1:0]   busy,
    output logic                  save_valid,
    input  logic                  save_ready,
    output logic [IDX_W-1:0]      save_chan,
    output logic                  save_is_out,
    output logic                  overflow
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_SHOW  = 3'd2,
        S_PAY   = 3'd3
    } lane_state_t;

`ifdef PGS_RETRIGGER_EN
    localparam bit RETRIGGER = 1'b1;
`else
    localparam bit RETRIGGER = 1'b0;
`endif

    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_TICKS - 1);
    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(EXIT_SHOW_TICKS - 1);
    localparam logic [CNT_W-1:0] PAY_LOAD   = CNT_W'(EXIT_PAY_TICKS - 1);

    lane_state_t         st_q  [CHANNELS];
    lane_state_t         st_d  [CHANNELS];
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];
    logic [CHANNELS-1:0] press_q, start, dir_q, dir_d, done;
    logic [CHANNELS-1:0] pend_q, pend_d, pdir_q, pdir_d;
    logic [IDX_W-1:0]    rr_q, rr_d, gnt_q, search_idx;
    logic                locked_q, ovf_d, xfer, found;

    assign start = press & ~press_q;

    always_comb begin : lane_next
        done = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            dir_d[i] = dir_q[i];
            if (start[i] && (st_q[i] == S_IDLE || RETRIGGER)) begin
                dir_d[i] = is_out[i];
                st_d[i]  = is_out[i] ? S_SHOW : S_ENTRY;
                cnt_d[i] = is_out[i] ? SHOW_LOAD : ENTRY_LOAD;
            end else begin
                case (st_q[i])
                    S_ENTRY, S_PAY: begin
                        if (cnt_q[i] != '0) begin
                            cnt_d[i] = cnt_q[i] - 1'b1;
                        end else begin
                            st_d[i] = S_IDLE;
                            done[i] = 1'b1;
                        end
                    end
                    S_SHOW: begin
                        if (cnt_q[i] != '0) begin
                            cnt_d[i] = cnt_q[i] - 1'b1;
                        end else begin
                            st_d[i]  = S_PAY;
                            cnt_d[i] = PAY_LOAD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // First pending lane at or after rr, searched cyclically.
    always_comb begin : rr_search
        search_idx = '0;
        found      = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!found && pend_q[(int'(rr_q) + k) % CHANNELS]) begin
                found      = 1'b1;
                search_idx = IDX_W'((int'(rr_q) + k) % CHANNELS);
            end
        end
    end

    // A presented but unaccepted request stays locked until it transfers.
    assign save_valid  = |pend_q;
    assign save_chan   = locked_q ? gnt_q : search_idx;
    assign save_is_out = save_valid & pdir_q[save_chan];
    assign xfer        = save_valid & save_ready;

    always_comb begin : save_next
        pend_d = pend_q;
        pdir_d = pdir_q;
        ovf_d  = overflow;
        rr_d   = rr_q;
        if (xfer) begin
            pend_d[save_chan] = 1'b0;
            rr_d = (int'(save_chan) == CHANNELS - 1) ? '0 : save_chan + 1'b1;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (done[i]) begin
                if (pend_d[i]) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
                    pdir_d[i] = dir_q[i];
                end
            end
        end
    end

    always_ff @(posedge ms or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i]  <= S_IDLE;
                cnt_q[i] <= '0;
            end
            press_q  <= '0;
            dir_q    <= '0;
            pend_q   <= '0;
            pdir_q   <= '0;
            rr_q     <= '0;
            gnt_q    <= '0;
            locked_q <= 1'b0;
            overflow <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            press_q  <= press;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            pdir_q   <= pdir_d;
            rr_q     <= rr_d;
            gnt_q    <= save_chan;
            locked_q <= save_valid & ~save_ready;
            overflow <= ovf_d;
        end
    end

    always_comb begin : pack_outputs
        state = '0;
        busy  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state[3*i +: 3] = st_q[i];
            busy[i]         = (st_q[i] != S_IDLE);
        end
    end
endmodule

// File: tb/tb_parking_gate_sequencer.sv
// tb/tb_parking_gate_sequencer.sv - randomized scoreboard bench for parking_gate_sequencer
module tb_parking_gate_sequencer;
    localparam int CH = 2;
    localparam int ET = 5;
    localparam int ST = 3;
    localparam int PT = 4;

    logic          ms = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] press = '0;
    logic [CH-1:0] is_out = '0;
    logic          save_ready = 1'b0;
    logic [3*CH-1:0] state;
    logic [CH-1:0] busy;
    logic          save_valid;
    logic [0:0]    save_chan;
    logic          save_is_out;
    logic          overflow;

    parking_gate_sequencer #(
        .CHANNELS(CH), .CNT_W(4), .IDX_W(1),
        .ENTRY_TICKS(ET), .EXIT_SHOW_TICKS(ST), .EXIT_PAY_TICKS(PT)
    ) dut (
        .ms(ms), .rst(rst), .press(press), .is_out(is_out),
        .state(state), .busy(busy), .save_valid(save_valid),
        .save_ready(save_ready), .save_chan(save_chan),
        .save_is_out(save_is_out), .overflow(overflow)
    );

    always #5 ms = ~ms;

    int n_checks = 0;
    int n_fail = 0;
    int sb_q[$];

    // Reference model: sequences tracked by start time and elapsed ticks.
    int n;
    bit m_act [CH];
    bit m_dir [CH];
    int m_t0 [CH];
    bit m_pend [CH];
    bit m_pdir [CH];
    bit [CH-1:0] m_prev;
    int m_rr;
    int m_cur;
    bit m_ovf;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int seq_len(input bit d);
        return d ? ST + PT : ET;
    endfunction

    function automatic int exp_state(input int i);
        int e;
        if (!m_act[i]) return 0;
        e = n - m_t0[i];
        if (!m_dir[i]) return 1;
        return (e < ST) ? 2 : 3;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_act[i] = 0; m_dir[i] = 0; m_t0[i] = 0; m_pend[i] = 0; m_pdir[i] = 0;
        end
        m_prev = '0; m_rr = 0; m_cur = -1; m_ovf = 0; n = 0;
    endtask

    task automatic present();
        if (m_cur < 0) begin
            for (int k = 0; k < CH; k++) begin
                if (m_cur < 0 && m_pend[(m_rr + k) % CH]) m_cur = (m_rr + k) % CH;
            end
        end
    endtask

    task automatic compare_outputs();
        bit anyp;
        present();
        anyp = 0;
        for (int i = 0; i < CH; i++) begin
            check($sformatf("state%0d", i), int'(state[3*i +: 3]), exp_state(i));
            check($sformatf("busy%0d", i), int'(busy[i]), int'(m_act[i]));
            anyp |= m_pend[i];
        end
        check("save_valid", int'(save_valid), int'(anyp));
        if (anyp) begin
            check("save_chan", int'(save_chan), m_cur);
            check("save_is_out", int'(save_is_out), int'(m_pdir[m_cur]));
        end
        check("overflow", int'(overflow), int'(m_ovf));
    endtask

    task automatic step(input logic [CH-1:0] p, input logic [CH-1:0] o, input logic r);
        bit start, restart;
        n++;
        if (m_cur >= 0 && r) begin
            sb_q.push_back(m_cur * 2 + int'(m_pdir[m_cur]));
            m_pend[m_cur] = 0;
            m_rr = (m_cur + 1) % CH;
            m_cur = -1;
        end
        for (int i = 0; i < CH; i++) begin
            start = p[i] & ~m_prev[i];
            restart = 0;
`ifdef PGS_RETRIGGER_EN
            restart = start && m_act[i];
`endif
            if (restart) begin
                m_t0[i] = n; m_dir[i] = o[i];
            end else if (m_act[i] && (n - m_t0[i]) == seq_len(m_dir[i])) begin
                m_act[i] = 0;
                if (m_pend[i]) m_ovf = 1;
                else begin m_pend[i] = 1; m_pdir[i] = m_dir[i]; end
            end else if (!m_act[i] && start) begin
                m_act[i] = 1; m_t0[i] = n; m_dir[i] = o[i];
            end
        end
        m_prev = p;
    endtask

    task automatic cycle(input logic [CH-1:0] p, input logic [CH-1:0] o, input logic r);
        compare_outputs();
        press = p; is_out = o; save_ready = r;
        step(p, o, r);
        @(negedge ms);
    endtask

    task automatic run(input logic [CH-1:0] p, input logic [CH-1:0] o, input logic r, input int cnt);
        for (int c = 0; c < cnt; c++) cycle(p, o, r);
    endtask

    task automatic pulse_reset(input logic [CH-1:0] p, input logic [CH-1:0] o);
        press = p; is_out = o; save_ready = 1'b1; rst = 1'b1;
        #1;
        check("rst_state", int'(state), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_save_valid", int'(save_valid), 0);
        check("rst_save_chan", int'(save_chan), 0);
        check("rst_save_is_out", int'(save_is_out), 0);
        check("rst_overflow", int'(overflow), 0);
        @(negedge ms);
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: every accepted transfer must match the oldest predicted one.
    initial begin
        int e;
        forever begin
            @(negedge ms);
            #2;
            if (!rst && save_valid && save_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_xfer", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_chan", int'(save_chan), e / 2);
                    check("sb_is_out", int'(save_is_out), e % 2);
                end
            end
        end
    end

    initial begin
        logic [CH-1:0] rp, ro;
        int rdy_pct;
        model_reset();
        @(negedge ms);
        pulse_reset('0, '0);

        // Lane 0 entry, lane 1 exit, then both completing together.
        run(2'b01, 2'b00, 1'b0, 1);
        run(2'b00, 2'b00, 1'b1, 7);
        run(2'b10, 2'b10, 1'b1, 1);
        run(2'b00, 2'b00, 1'b1, 9);
        for (int rep = 0; rep < 2; rep++) begin
            run(2'b11, 2'b00, 1'b1, 1);
            run(2'b00, 2'b00, 1'b1, 8);
        end

        // Two lane-0 completions without ready -> overflow.
        run(2'b01, 2'b00, 1'b0, 1);
        run(2'b00, 2'b00, 1'b0, 5);
        run(2'b01, 2'b00, 1'b0, 1);
        run(2'b00, 2'b00, 1'b0, 6);
        run(2'b00, 2'b00, 1'b1, 3);

        // Second press during ENTRY.
        run(2'b01, 2'b00, 1'b0, 1);
        run(2'b00, 2'b00, 1'b0, 2);
        run(2'b01, 2'b00, 1'b0, 1);
        run(2'b00, 2'b00, 1'b1, 9);

        // Reset mid-EXIT_PAY with a pending save, press held through release.
        run(2'b11, 2'b10, 1'b0, 1);
        run(2'b00, 2'b00, 1'b0, 5);
        pulse_reset(2'b11, 2'b10);
        run(2'b11, 2'b10, 1'b1, 1);
        run(2'b00, 2'b00, 1'b1, 10);

        for (int blk = 0; blk < 15; blk++) begin
            rdy_pct = $urandom_range(0, 100);
            for (int c = 0; c < 200; c++) begin
                for (int i = 0; i < CH; i++) begin
                    rp[i] = ($urandom_range(0, 3) == 0);
                    ro[i] = $urandom_range(0, 1);
                end
                cycle(rp, ro, ($urandom_range(0, 99) < rdy_pct));
            end
            if (blk % 5 == 4) pulse_reset('0, '0);
        end

        run(2'b00, 2'b00, 1'b1, 12);
        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
